debug_reg_scanner: RTL

- Reader side of the processor's debug register port.
- Drives `debug_reg_select` on the computer module and samples `debug_reg_out` and `PC`.
- Walks the register file and serialises a dump frame onto a byte stream with a valid/ready handshake (feeds the UART transmitter).
- One frame per start request.

---
 rtl/debug_reg_scanner.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/debug_reg_scanner.sv
// ============================================================================
// debug_reg_scanner: walks the CPU debug register port, streams a dump frame.
// Optional: DBG_CHECKSUM_EN appends an XOR checksum byte.   Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module debug_reg_scanner #(
  parameter int          NUM_REGS      = 32,
  parameter int          SETTLE_CYCLES = 1,
  parameter logic [7:0]  HDR_BYTE      = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [4:0]  debug_reg_select,
  input  logic [31:0] debug_reg_out,
  input  logic [31:0] PC,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] LAST_IDX    = 5'(NUM_REGS - 1);
  localparam logic [3:0] LAST_SETTLE = 4'(SETTLE_CYCLES - 1);

`ifdef DBG_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_PCB, S_SEL, S_RB, S_FIN, S_CSUM
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_PCB, S_SEL, S_RB, S_FIN
  } state_t;
`endif

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] reg_q, reg_d;
  logic [4:0]  idx_q, idx_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [3:0]  settle_q, settle_d;
`ifdef DBG_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  // Byte 0 of a word is its most significant byte.
  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] b);
    return w[{~b, 3'b000} +: 8];
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      reg_q    <= '0;
      idx_q    <= '0;
      bcnt_q   <= '0;
      settle_q <= '0;
`ifdef DBG_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      reg_q    <= reg_d;
      idx_q    <= idx_d;
      bcnt_q   <= bcnt_d;
      settle_q <= settle_d;
`ifdef DBG_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

  // Outputs are decoded from registered state only, so tx_data/tx_valid
  // cannot change while a byte waits for tx_ready.
  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    reg_d            = reg_q;
    idx_d            = idx_q;
    bcnt_d           = bcnt_q;
    settle_d         = settle_q;
`ifdef DBG_CHECKSUM_EN
    csum_d           = csum_q;
`endif
    debug_reg_select = 5'd0;
    tx_data          = 8'd0;
    tx_valid         = 1'b0;
    busy             = 1'b1;
    done             = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          pc_d     = PC;
          idx_d    = 5'd0;
          bcnt_d   = 2'd0;
          settle_d = 4'd0;
`ifdef DBG_CHECKSUM_EN
          csum_d   = 8'd0;
`endif
          state_d  = S_HDR;
        end
      end

      S_HDR: begin
        tx_valid = 1'b1;
        tx_data  = HDR_BYTE;
        if (tx_ready) begin
          bcnt_d  = 2'd0;
          state_d = S_PCB;
        end
      end

      S_PCB: begin
        tx_valid = 1'b1;
        tx_data  = byte_of(pc_q, bcnt_q);
        if (tx_ready) begin
`ifdef DBG_CHECKSUM_EN
          csum_d = csum_q ^ tx_data;
`endif
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            idx_d    = 5'd0;
            settle_d = 4'd0;
            state_d  = S_SEL;
          end
        end
      end

      S_SEL: begin
        debug_reg_select = idx_q;
        if (settle_q == LAST_SETTLE) begin
          reg_d    = debug_reg_out;
          settle_d = 4'd0;
          bcnt_d   = 2'd0;
          state_d  = S_RB;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end

      S_RB: begin
        debug_reg_select = idx_q;
        tx_valid         = 1'b1;
        tx_data          = byte_of(reg_q, bcnt_q);
        if (tx_ready) begin
`ifdef DBG_CHECKSUM_EN
          csum_d = csum_q ^ tx_data;
`endif
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            if (idx_q == LAST_IDX) begin
`ifdef DBG_CHECKSUM_EN
              state_d = S_CSUM;
`else
              state_d = S_FIN;
`endif
            end else begin
              idx_d    = idx_q + 5'd1;
              settle_d = 4'd0;
              state_d  = S_SEL;
            end
          end
        end
      end

`ifdef DBG_CHECKSUM_EN
      S_CSUM: begin
        tx_valid = 1'b1;
        tx_data  = csum_q;
        if (tx_ready) state_d = S_FIN;
      end
`endif

      S_FIN: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        busy    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire
